fb_cmd_scheduler: RTL and testbench

- Sequences the 128x64 monochrome FrameBuffer (8 pages x 128 columns, 1024 bytes).
- Shares the FrameBuffer between two requesters:
  - CPU draw-command queue: pixel, colour, word and line operations.
  - Display refresh engine: byte-by-byte readout via send_next_data/frame_address.
- Issues one FrameBuffer operation at a time, honours busy, and owns page01 (double-buffer select), swapping only at frame boundaries.

---
 rtl/fb_sched_if.sv | 53 +++++
 rtl/fb_cmd_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_fb_cmd_scheduler.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_sched_if
//  Brief    : Bundle of CPU command, refresh and FrameBuffer signals around
//             the FrameBuffer command scheduler.
//  Revision : 1.0
// ============================================================================
interface fb_sched_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_x;
    logic [5:0] cmd_y;
    logic [7:0] cmd_word;
    logic       refresh_req;
    logic       refresh_ack;
    logic       swap_req;
    logic       frame_done;
    logic       busy;
    logic       set_pixel;
    logic       set_colour;
    logic       set_word;
    logic       set_pixel_line;
    logic       send_next_data;
    logic [6:0] x_coord_pix;
    logic [5:0] y_coord_pix;
    logic [6:0] x_coord_wrd;
    logic [2:0] y_coord_wrd;
    logic [7:0] word_in;
    logic [9:0] frame_address;
    logic       page01;

    // Scheduler side
    modport master (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_word,
        input  refresh_req, swap_req, busy,
        output cmd_ready, refresh_ack, frame_done,
        output set_pixel, set_colour, set_word, set_pixel_line, send_next_data,
        output x_coord_pix, y_coord_pix, x_coord_wrd, y_coord_wrd, word_in,
        output frame_address, page01
    );

    // Requester / FrameBuffer side
    modport slave (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_word,
        output refresh_req, swap_req, busy,
        input  cmd_ready, refresh_ack, frame_done,
        input  set_pixel, set_colour, set_word, set_pixel_line, send_next_data,
        input  x_coord_pix, y_coord_pix, x_coord_wrd, y_coord_wrd, word_in,
        input  frame_address, page01
    );
endinterface
`default_nettype wire

// File: rtl/fb_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fb_cmd_scheduler
//  Brief    : Arbitrates CPU draw commands and display refresh reads onto the
//             128x64 FrameBuffer, one operation at a time; owns page01.
//             Optional macro FB_SCHED_FAIR_EN forces a CPU slot after
//             FAIR_LIMIT consecutive refresh grants.
//  Revision : 1.0
// ============================================================================
module fb_cmd_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int FRAME_BYTES = 1024,
    parameter int FAIR_LIMIT  = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fb_sched_if.master   bus
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [9:0] ADDR_LAST = 10'(FRAME_BYTES - 1);
    localparam logic [1:0] OP_PIXEL  = 2'd0;
    localparam logic [1:0] OP_COLOUR = 2'd1;
    localparam logic [1:0] OP_WORD   = 2'd2;
    localparam logic [1:0] OP_LINE   = 2'd3;

    typedef struct packed {
        logic [1:0] op;
        logic [6:0] x;
        logic [5:0] y;
        logic [7:0] word;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE_CMD = 3'd1,
        S_WAIT_CMD  = 3'd2,
        S_ISSUE_RD  = 3'd3,
        S_WAIT_RD   = 3'd4
    } state_t;

    // ------------------------------------------------------------------ FIFO
    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          push, pop, fifo_empty;
    cmd_t          head;

    assign push       = bus.cmd_valid & bus.cmd_ready;
    assign fifo_empty = (count == '0);
    assign head       = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{op: bus.cmd_op, x: bus.cmd_x, y: bus.cmd_y, word: bus.cmd_word};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count         <= count_next;
            bus.cmd_ready <= (count_next != (AW+1)'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------ FSM
    state_t state, state_next;
    logic   wait_first;
    logic   grant_cmd, grant_rd, done_rd, frame_end, force_cpu;

`ifdef FB_SCHED_FAIR_EN
    localparam int FCW = $clog2(FAIR_LIMIT + 1);
    logic [FCW-1:0] fair_cnt;

    assign force_cpu = (fair_cnt >= FCW'(FAIR_LIMIT)) && !fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fair_cnt <= '0;
        else if (grant_cmd)
            fair_cnt <= '0;
        else if (grant_rd && !fifo_empty)
            fair_cnt <= fair_cnt + 1'b1;
    end
`else
    assign force_cpu = 1'b0;
`endif

    always_comb begin
        state_next = state;
        grant_cmd  = 1'b0;
        grant_rd   = 1'b0;
        done_rd    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!bus.busy) begin
                    if (bus.refresh_req && !force_cpu) begin
                        grant_rd   = 1'b1;
                        state_next = S_ISSUE_RD;
                    end else if (!fifo_empty) begin
                        grant_cmd  = 1'b1;
                        state_next = S_ISSUE_CMD;
                    end
                end
            end
            S_ISSUE_CMD: state_next = S_WAIT_CMD;
            S_ISSUE_RD:  state_next = S_WAIT_RD;
            // First wait cycle ignores busy: the FrameBuffer has not yet sampled the strobe
            S_WAIT_CMD: begin
                if (!wait_first && !bus.busy)
                    state_next = S_IDLE;
            end
            S_WAIT_RD: begin
                if (!wait_first && !bus.busy) begin
                    done_rd    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pop       = grant_cmd;
    assign frame_end = done_rd && (bus.frame_address == ADDR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_first <= 1'b0;
        end else begin
            state      <= state_next;
            wait_first <= (state == S_ISSUE_CMD) || (state == S_ISSUE_RD);
        end
    end

    // ------------------------------------------------------ registered outputs
    // Strobes are registered on the grant edge so they coincide with the ISSUE state.
    logic swap_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.set_pixel      <= 1'b0;
            bus.set_colour     <= 1'b0;
            bus.set_word       <= 1'b0;
            bus.set_pixel_line <= 1'b0;
            bus.send_next_data <= 1'b0;
            bus.x_coord_pix    <= '0;
            bus.y_coord_pix    <= '0;
            bus.x_coord_wrd    <= '0;
            bus.y_coord_wrd    <= '0;
            bus.word_in        <= '0;
            bus.refresh_ack    <= 1'b0;
            bus.frame_done     <= 1'b0;
            bus.frame_address  <= '0;
            bus.page01         <= 1'b0;
            swap_pending       <= 1'b0;
        end else begin
            bus.set_pixel      <= grant_cmd && (head.op == OP_PIXEL);
            bus.set_colour     <= grant_cmd && (head.op == OP_COLOUR);
            bus.set_word       <= grant_cmd && (head.op == OP_WORD);
            bus.set_pixel_line <= grant_cmd && (head.op == OP_LINE);
            bus.send_next_data <= grant_rd;
            if (grant_cmd) begin
                if (head.op == OP_WORD) begin
                    bus.x_coord_wrd <= head.x;
                    bus.y_coord_wrd <= head.y[2:0];
                    bus.word_in     <= head.word;
                end else begin
                    bus.x_coord_pix <= head.x;
                    bus.y_coord_pix <= head.y;
                end
            end
            bus.refresh_ack <= done_rd;
            bus.frame_done  <= frame_end;
            if (done_rd)
                bus.frame_address <= frame_end ? '0 : bus.frame_address + 1'b1;
            if (frame_end) begin
                if (swap_pending)
                    bus.page01 <= ~bus.page01;
                swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fb_cmd_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_cmd_scheduler
//  Brief    : Directed self-checking bench for fb_cmd_scheduler.
//  Revision : 1.0
// ============================================================================
module tb_fb_cmd_scheduler;
    logic clk = 1'b0;
    logic reset;
    logic busy_man;
    logic auto_busy = 1'b0;
    logic auto_b    = 1'b0;
    int   bcnt      = 0;
    int   errors    = 0;
    int   checks    = 0;

    fb_sched_if bus ();

    fb_cmd_scheduler #(
        .FIFO_DEPTH (4),
        .FRAME_BYTES(1024),
        .FAIR_LIMIT (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    assign bus.busy = auto_busy ? auto_b : busy_man;

    logic any_strobe;
    assign any_strobe = bus.set_pixel | bus.set_colour | bus.set_word |
                        bus.set_pixel_line | bus.send_next_data;

    // FrameBuffer model: busy for the strobe cycle and the two following cycles
    initial forever begin
        @(posedge clk);
        #1;
        if (any_strobe) bcnt = 3;
        auto_b = (bcnt != 0);
        if (bcnt != 0) bcnt--;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    int   n, nw, sends, acks, fd_cnt, fd_at, addr_err, page_err, exp_addr;
    int   n_rd, col_after, extra;
    logic col_seen, strobes_seen;
    logic [4:0] rdy;

    initial begin
        reset = 1'b1;
        busy_man = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_x = 7'd5; bus.cmd_y = 6'd9;
        bus.cmd_word = 8'd0; bus.refresh_req = 1'b0; bus.swap_req = 1'b0;

        // ---- reset state, then one SET_PIXEL queued across reset release
        repeat (3) @(negedge clk);
        check_eq("rst_strobes", {27'd0, any_strobe}, 0);
        check_eq("rst_page01", {31'd0, bus.page01}, 0);
        check_eq("rst_ready", {31'd0, bus.cmd_ready}, 1);
        check_eq("rst_ack_done", {30'd0, bus.refresh_ack, bus.frame_done}, 0);
        check_eq("rst_faddr", {22'd0, bus.frame_address}, 0);
        reset = 1'b0;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.set_pixel && n < 20) begin @(negedge clk); n++; end
        check_eq("pix_timeout", {31'd0, n < 20}, 1);
        check_eq("pix_x", {25'd0, bus.x_coord_pix}, 5);
        check_eq("pix_y", {26'd0, bus.y_coord_pix}, 9);
        extra = 0;
        repeat (10) begin @(negedge clk); if (bus.set_pixel) extra++; end
        check_eq("pix_one_cycle", extra, 0);

        // ---- fill FIFO while busy; IDLE must not grant
        busy_man = 1'b1;
        strobes_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_x = 7'(10 + i);
            bus.cmd_y = 6'd3; bus.cmd_word = 8'hEB;
            rdy[i] = bus.cmd_ready;
            @(negedge clk);
            strobes_seen |= any_strobe;
        end
        bus.cmd_valid = 1'b0;
        check_eq("ready_pattern", {27'd0, rdy}, 5'b01111);
        check_eq("busy_no_grant", {31'd0, strobes_seen}, 0);
        busy_man = 1'b0;
        nw = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.set_word) begin
                check_eq("wrd_x", {25'd0, bus.x_coord_wrd}, 32'(10 + nw));
                check_eq("wrd_y_word", {21'd0, bus.y_coord_wrd, bus.word_in}, {21'd0, 3'd3, 8'hEB});
                nw++;
            end
        end
        check_eq("wrd_count", nw, 4);

        // ---- full refresh frame with two swap requests mid-frame
        auto_busy = 1'b1;
        bus.refresh_req = 1'b1;
        sends = 0; acks = 0; fd_cnt = 0; fd_at = 0; addr_err = 0; page_err = 0; exp_addr = 0;
        n = 0;
        while (sends < 1025 && n < 20000) begin
            @(negedge clk);
            n++;
            bus.swap_req = 1'b0;
            if (bus.send_next_data) begin
                if (bus.frame_address != 10'(exp_addr)) addr_err++;
                exp_addr = (exp_addr + 1) % 1024;
                sends++;
            end
            if (bus.refresh_ack) begin
                acks++;
                if (bus.frame_done) begin
                    fd_cnt++;
                    fd_at = acks;
                    if (bus.page01 !== 1'b1) page_err++;
                end
                if (acks == 300 || acks == 310) bus.swap_req = 1'b1;
            end
            if (!bus.frame_done && bus.page01 !== (fd_cnt > 0)) page_err++;
        end
        bus.refresh_req = 1'b0;
        check_eq("frame_sends", sends, 1025);
        check_eq("frame_addr_seq", addr_err, 0);
        check_eq("frame_done_cnt", fd_cnt, 1);
        check_eq("frame_done_at", fd_at, 1024);
        check_eq("page_swap_once", page_err, 0);
        repeat (10) @(negedge clk);
        check_eq("page01_final", {31'd0, bus.page01}, 1);

        // ---- refresh held with one SET_COLOUR queued
        bus.refresh_req = 1'b1;
        n = 0;
        while (!bus.send_next_data && n < 20) begin @(negedge clk); n++; end
        check_eq("prio_rd_start", {31'd0, n < 20}, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_x = 7'd3; bus.cmd_y = 6'd4;
        rdy[0] = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check_eq("prio_push_rdy", {31'd0, rdy[0]}, 1);
        n_rd = 0; col_seen = 1'b0; col_after = -1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.set_colour && !col_seen) begin col_seen = 1'b1; col_after = n_rd; end
            if (bus.send_next_data) n_rd++;
        end
`ifdef FB_SCHED_FAIR_EN
        check_eq("fair_colour_seen", {31'd0, col_seen}, 1);
        check_eq("fair_colour_after", col_after, 4);
`else
        check_eq("strict_no_colour", {31'd0, col_seen}, 0);
`endif
        bus.refresh_req = 1'b0;
        n = 0;
        while (!col_seen && n < 30) begin
            @(negedge clk); n++;
            if (bus.set_colour) col_seen = 1'b1;
        end
        check_eq("colour_issued", {31'd0, col_seen}, 1);
        check_eq("colour_x", {25'd0, bus.x_coord_pix}, 3);
        repeat (10) @(negedge clk);

        // ---- reset during WAIT_RD
        bus.refresh_req = 1'b1;
        n = 0;
        while (!bus.send_next_data && n < 20) begin @(negedge clk); n++; end
        check_eq("rstrd_start", {31'd0, n < 20}, 1);
        @(negedge clk);
        reset = 1'b1;
        bus.refresh_req = 1'b0;
        #1;
        check_eq("rstrd_ack", {31'd0, bus.refresh_ack}, 0);
        check_eq("rstrd_faddr", {22'd0, bus.frame_address}, 0);
        check_eq("rstrd_page01", {31'd0, bus.page01}, 0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (10) begin @(negedge clk); if (bus.refresh_ack || any_strobe) extra++; end
        check_eq("rstrd_quiet", extra, 0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_x = 7'd77; bus.cmd_y = 6'd33;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.set_pixel_line && n < 10) begin @(negedge clk); n++; end
        check_eq("rstrd_idle_grant", {31'd0, n < 10}, 1);
        check_eq("line_xy", {19'd0, bus.x_coord_pix, bus.y_coord_pix}, {19'd0, 7'd77, 6'd33});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
